stream_arb_2x1: RTL
===================

// Module: stream_arb_2x1
// PURPOSE
// - Upstream select stage for the 2:1 gate-level mux datapath: round-robin arbiter between two
//   valid/ready streams that produces the mux select and forwards the winning beat.
// - Registered output stage: 1-cycle latency, full throughput (1 beat/cycle) under back-pressure.
// - Optional packet lock keeps a multi-beat packet from one source contiguous.
// PARAMETERS
// - DW    8   data width of i0_data, i1_data, y_data
// PORTS
// - clk       in   1   single clock, all state updates on rising edge
// - rst       in   1   reset, synchronous, active-high
// - i0_data   in   DW  source 0 data
// - i0_valid  in   1   source 0 beat available
// - i0_ready  out  1   source 0 beat accepted this cycle (when i0_valid & i0_ready)
// - i1_data   in   DW  source 1 data
// - i1_valid  in   1   source 1 beat available
// - i1_ready  out  1   source 1 beat accepted this cycle
// - s         out  1   current select, combinational: 0 = i0, 1 = i1
// - y_data    out  DW  registered output data
// - y_valid   out  1   registered output valid
// - y_ready   in   1   downstream accepts y_data when y_valid & y_ready
// BEHAVIOUR
// - Reset: y_valid=0, y_data=0, prio=0 (i0 preferred), lock state ARB. Clears any beat in flight.
// - load = !y_valid | y_ready. Beat accepted when load & selected source valid.
// - Select (state ARB): only i0_valid -> s=0; only i1_valid -> s=1; both -> s=prio;
//   neither -> s=prio, no accept.
// - i0_ready = load & (s==0); i1_ready = load & (s==1). ready may depend on valid (documented).
// - On accept: y_data<=mux(s), y_valid<=1, prio<=~s (loser of a tie wins next time).
// - On y_valid & y_ready with no accept: y_valid<=0, y_data holds.
// - Simultaneous drain and accept: y_data replaced, y_valid stays 1; no bubble, no loss.
// - y_data/y_valid stable while y_valid & !y_ready.
// - Fairness: both valid continuously -> strict alternation 0,1,0,1...
// - No FSM beyond prio when macro absent.
// CONFIGURATION
// - ARB_PKT_LOCK_EN defined: adds ports i0_last, i1_last (in, 1) and y_last (out, 1, registered
//   with y_data, reset 0). FSM states ARB, LOCK0, LOCK1:
//   ARB -> LOCKn on accept from source n with last=0; LOCKn -> ARB on accept from n with last=1.
//   In LOCKn: s=n regardless of other valid; prio updated only on last-beat accept.
//   Single-beat packet (last=1 on first beat) stays in ARB.
// - ARB_PKT_LOCK_EN undefined: no last ports, every beat arbitrated independently.
// STRUCTURE
// - Package stream_arb_pkg: DW default, lock state enum {ARB, LOCK0, LOCK1}, SEL_I0/SEL_I1 consts.
// - Sub-module rr_pick_2: combinational (v0, v1, prio, lock state) -> s; keeps top to
//   handshake + output register.
// - Data select implemented with the team's 2:1 gate mux, one instance per data bit.
// TESTING
// - Reset: rst=1 2 cycles with both valid -> y_valid=0, y_data=0, i0_ready=i1_ready=0
//   after rst falls.
// - Tie: i0=0x11, i1=0x22 held valid, y_ready=1 -> y_data 0x11, 0x22, 0x11 on consecutive cycles.
// - Back-pressure: y_ready=0 with y_valid=1 for 3 cycles -> both readys 0, y_data stable;
//   release -> next beat same cycle.
// - Single source: only i1_valid, 4 beats 0xA0..0xA3 -> s=1, out in order, 1-cycle latency each.
// - Reset mid-stream: rst=1 while y_valid=1 -> next cycle y_valid=0, prio=0; i0 wins next tie.
// - ARB_PKT_LOCK_EN: i0 3-beat pkt (last on beat 3), i1 valid all along -> i0 beats contiguous,
//   then i1 granted.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the 2:1 stream arbiter.
package stream_arb_pkg;
  localparam int   DW_DEF = 8;
  localparam logic SEL_I0 = 1'b0;
  localparam logic SEL_I1 = 1'b1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_e;
endpackage

// File: rtl/mux2_gate.sv
// Single-bit 2:1 mux built from AND/OR gates; sel=0 passes a, sel=1 passes b.
module mux2_gate (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  logic sel_n, t0, t1;

  assign sel_n = ~sel;
  assign t0    = a & sel_n;
  assign t1    = b & sel;
  assign y     = t0 | t1;
endmodule

// File: rtl/rr_pick_2.sv
// Combinational round-robin pick between two requesters, with an optional lock override.
module rr_pick_2
  import stream_arb_pkg::*;
(
  input  logic  v0,
  input  logic  v1,
  input  logic  prio,
  input  lock_e lock_st,
  output logic  s
);
  always_comb begin
    s = prio;
    case (lock_st)
      LOCK0:   s = SEL_I0;
      LOCK1:   s = SEL_I1;
      default: begin
        // Idle or tie both fall back to prio, so ready is predictable with no valid.
        if (v0 && !v1)      s = SEL_I0;
        else if (v1 && !v0) s = SEL_I1;
        else                s = prio;
      end
    endcase
  end
endmodule

// File: rtl/stream_arb_2x1.sv
// Round-robin 2:1 valid/ready arbiter with registered output stage.
// Define ARB_PKT_LOCK_EN to add last flags and hold the grant for a whole packet.
module stream_arb_2x1
  import stream_arb_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i0_data,
  input  logic          i0_valid,
  output logic          i0_ready,
  input  logic [DW-1:0] i1_data,
  input  logic          i1_valid,
  output logic          i1_ready,
`ifdef ARB_PKT_LOCK_EN
  input  logic          i0_last,
  input  logic          i1_last,
  output logic          y_last,
`endif
  output logic          s,
  output logic [DW-1:0] y_data,
  output logic          y_valid,
  input  logic          y_ready
);
  logic          load, sel_valid, sel_last, accept;
  logic [DW-1:0] mux_y;
  logic [DW-1:0] y_data_q, y_data_d;
  logic          y_valid_q, y_valid_d;
  logic          prio_q, prio_d;
  lock_e         lock_st;

  assign load = ~y_valid_q | y_ready;

  rr_pick_2 u_pick (
    .v0      (i0_valid),
    .v1      (i1_valid),
    .prio    (prio_q),
    .lock_st (lock_st),
    .s       (s)
  );

  // Ready is held low during reset so nothing is consumed while the stage clears.
  assign sel_valid = (s == SEL_I1) ? i1_valid : i0_valid;
  assign i0_ready  = load & ~rst & (s == SEL_I0);
  assign i1_ready  = load & ~rst & (s == SEL_I1);
  assign accept    = load & ~rst & sel_valid;

  for (genvar b = 0; b < DW; b++) begin : g_mux
    mux2_gate u_mux (
      .a   (i0_data[b]),
      .b   (i1_data[b]),
      .sel (s),
      .y   (mux_y[b])
    );
  end

`ifdef ARB_PKT_LOCK_EN
  lock_e lock_q, lock_d;
  logic  y_last_q, y_last_d;

  assign sel_last = (s == SEL_I1) ? i1_last : i0_last;

  always_ff @(posedge clk) begin
    if (rst) lock_q <= ARB;
    else     lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      ARB:     if (accept && !sel_last) lock_d = (s == SEL_I1) ? LOCK1 : LOCK0;
      LOCK0,
      LOCK1:   if (accept && sel_last)  lock_d = ARB;
      default: lock_d = ARB;
    endcase
  end

  always_comb begin
    lock_st = lock_q;
  end

  always_comb begin
    y_last_d = y_last_q;
    if (accept) y_last_d = sel_last;
  end

  always_ff @(posedge clk) begin
    if (rst) y_last_q <= 1'b0;
    else     y_last_q <= y_last_d;
  end

  assign y_last = y_last_q;
`else
  assign sel_last = 1'b1;
  assign lock_st  = ARB;
`endif

  // prio flips only at packet boundaries; every beat is a boundary without lock.
  always_comb begin
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    prio_d    = prio_q;
    if (accept) begin
      y_data_d  = mux_y;
      y_valid_d = 1'b1;
      if (sel_last) prio_d = ~s;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      prio_q    <= 1'b0;
    end else begin
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      prio_q    <= prio_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
endmodule
